// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types for the systolic result drain
package systolic_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_RUN,
    DRAIN_DONE
  } drain_state_t;

endpackage

// File: rtl/systolic_rc_counter.sv
// rtl/systolic_rc_counter.sv - row-major row/column walker for a size x size matrix
module systolic_rc_counter
  import systolic_pkg::*;
#(
  parameter int size = 4,
  parameter int sw   = $clog2(size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [sw-1:0] r,
  output logic [sw-1:0] c,
  output logic          wrap,
  output logic          last
);

  assign wrap = (c == sw'(size - 1));
  assign last = wrap && (r == sw'(size - 1));

  // Step column each enable, carry into row on wrap; park on the final element.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r <= '0;
      c <= '0;
    end else if (en && !last) begin
      if (wrap) begin
        c <= '0;
        r <= r + sw'(1);
      end else begin
        c <= c + sw'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_out_drain.sv
// rtl/systolic_out_drain.sv - drains the systolic result matrix onto a val/rdy stream
module systolic_out_drain
  import systolic_pkg::*;
#(
  parameter int size  = 4,
  parameter int nbits = 16,
  parameter int sw    = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_rdy,
  input  logic [nbits-1:0] b_s_out,
  output logic [sw-1:0]    out_rsel,
  output logic [sw-1:0]    out_csel,
  output logic [nbits-1:0] send_msg,
  output logic [sw-1:0]    send_row,
  output logic [sw-1:0]    send_col,
  output logic             send_last,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             drain_busy,
  output logic             drain_done
);

  drain_state_t  state, state_nxt;
  logic          issued;
  logic          cap;
  logic          xfer;
  logic          cnt_clr;
  logic [sw-1:0] r, c;
  logic          wrap, last;

  assign xfer     = send_val && send_rdy;
  assign out_rsel = r;
  assign out_csel = c;

  systolic_rc_counter #(.size(size), .sw(sw)) u_rc (
    .clk  (clk),
    .rst  (rst),
    .en   (cap),
    .clr  (cnt_clr),
    .r    (r),
    .c    (c),
    .wrap (wrap),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DRAIN_IDLE;
    else     state <= state_nxt;
  end

  // Next state, capture strobe and status; DONE holds until out_rdy drops so a matrix drains once.
  always_comb begin
    state_nxt  = state;
    cap        = 1'b0;
    cnt_clr    = 1'b0;
    drain_busy = 1'b0;
    drain_done = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        cnt_clr = 1'b1;
        if (out_rdy) state_nxt = DRAIN_RUN;
      end
      DRAIN_RUN: begin
        drain_busy = 1'b1;
        cap        = !issued && (!send_val || send_rdy);
        if (xfer && send_last) begin
          drain_done = 1'b1;
          state_nxt  = DRAIN_DONE;
        end
      end
      DRAIN_DONE: begin
        drain_busy = 1'b1;
        if (!out_rdy) state_nxt = DRAIN_IDLE;
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  // Marks that the final element has been captured so the parked counter is not re-read.
  always_ff @(posedge clk) begin
    if (rst || state == DRAIN_IDLE) issued <= 1'b0;
    else if (cap && last)           issued <= 1'b1;
  end

  // Output stage: reload on capture (also covers transfer+capture), otherwise empty on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_val  <= 1'b0;
      send_msg  <= '0;
      send_row  <= '0;
      send_col  <= '0;
      send_last <= 1'b0;
    end else if (cap) begin
      send_val  <= 1'b1;
      send_msg  <= b_s_out;
      send_row  <= r;
      send_col  <= c;
      send_last <= wrap && (r == sw'(size - 1));
    end else if (xfer) begin
      send_val  <= 1'b0;
    end
  end

endmodule
